// File: rtl/game_progress_tracker.sv
// Game-side partner of the control FSM: runs the countdown or the character budget,
// keeps keystroke/elapsed statistics and drives finish plus BCD display digits.
module game_progress_tracker #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int ELAPSED_MAX   = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        Mode,
  input  logic [6:0]  value,
  input  logic        char_valid,
  input  logic        char_correct,
  output logic        finish,
  output logic [6:0]  remaining,
  output logic [7:0]  correct_cnt,
  output logic [7:0]  error_cnt,
  output logic [9:0]  elapsed,
  output logic [15:0] disp
);

  localparam int            PW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [9:0]    E_MAX  = 10'(ELAPSED_MAX);

  localparam logic [1:0] ST_SELECT    = 2'd0;
  localparam logic [1:0] ST_COUNTDOWN = 2'd1;
  localparam logic [1:0] ST_INGAME    = 2'd2;
  localparam logic [1:0] ST_FINISH    = 2'd3;

  logic          r_finish;
  logic [6:0]    r_remaining;
  logic [7:0]    r_correct;
  logic [7:0]    r_error;
  logic [9:0]    r_elapsed;
  logic [PW-1:0] r_presc;

  logic          w_tick;
  logic          w_hit;
  logic          w_miss;
  logic          w_dec;
  logic [11:0]   w_rem_bcd;
  logic [11:0]   w_cor_bcd;
  logic [15:0]   w_disp;

  // Shift-and-add-3 binary to three BCD digits; inputs here never exceed 255.
  function automatic logic [11:0] to_bcd(input logic [7:0] bin);
    logic [11:0] bcd;
    bcd = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
      if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
      if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
      bcd = {bcd[10:0], bin[i]};
    end
    return bcd;
  endfunction

  assign w_tick = (r_presc == P_LAST);
  assign w_hit  = char_valid & char_correct;
  assign w_miss = char_valid & ~char_correct;
  // Time mode burns remaining on the second tick, count mode on a correct keystroke.
  assign w_dec  = (r_remaining != 7'd0) && (Mode ? w_hit : w_tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_finish    <= 1'b0;
      r_remaining <= '0;
      r_correct   <= '0;
      r_error     <= '0;
      r_elapsed   <= '0;
      r_presc     <= '0;
    end else begin
      case (state)
        ST_SELECT, ST_COUNTDOWN: begin
          r_finish    <= 1'b0;
          r_remaining <= value;
          r_correct   <= '0;
          r_error     <= '0;
          r_elapsed   <= '0;
          r_presc     <= '0;
        end
        ST_INGAME: begin
          if (!r_finish) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick && (r_elapsed < E_MAX)) r_elapsed <= r_elapsed + 10'd1;
            if (w_hit && (r_correct != 8'hFF)) r_correct <= r_correct + 8'd1;
            if (w_miss && (r_error != 8'hFF))  r_error   <= r_error + 8'd1;
            if (w_dec) r_remaining <= r_remaining - 7'd1;
            if (r_remaining == 7'd0) r_finish <= 1'b1;
          end
        end
        ST_FINISH: begin
          r_finish <= r_finish;
        end
        default: begin
          r_finish <= r_finish;
        end
      endcase
    end
  end

  assign w_rem_bcd = to_bcd({1'b0, r_remaining});
  assign w_cor_bcd = to_bcd(r_correct);

  always_comb begin
    w_disp = 16'hCCCC;
    case (state)
      ST_INGAME: w_disp = {4'd0, w_rem_bcd};
      ST_FINISH: w_disp = {4'd13, w_cor_bcd};
      default:   w_disp = 16'hCCCC;
    endcase
  end

  assign finish      = r_finish;
  assign remaining   = r_remaining;
  assign correct_cnt = r_correct;
  assign error_cnt   = r_error;
  assign elapsed     = r_elapsed;
  assign disp        = w_disp;

endmodule

// File: tb/tb_game_progress_tracker.sv
// Directed bench for game_progress_tracker with a 10-cycle game second.
module tb_game_progress_tracker;

  logic        clk;
  logic        rst;
  logic [1:0]  state;
  logic        Mode;
  logic [6:0]  value;
  logic        char_valid;
  logic        char_correct;
  logic        finish;
  logic [6:0]  remaining;
  logic [7:0]  correct_cnt;
  logic [7:0]  error_cnt;
  logic [9:0]  elapsed;
  logic [15:0] disp;

  int n_cmp;
  int n_err;

  game_progress_tracker #(.TICKS_PER_SEC(10), .ELAPSED_MAX(999)) dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .Mode         (Mode),
    .value        (value),
    .char_valid   (char_valid),
    .char_correct (char_correct),
    .finish       (finish),
    .remaining    (remaining),
    .correct_cnt  (correct_cnt),
    .error_cnt    (error_cnt),
    .elapsed      (elapsed),
    .disp         (disp)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic ok);
    char_valid   = 1'b1;
    char_correct = ok;
    step(1);
    char_valid   = 1'b0;
    step(2);
  endtask

  task automatic start_game(input logic m, input logic [6:0] v);
    Mode  = m;
    value = v;
    state = 2'd0;
    step(1);
    state = 2'd1;
    step(1);
    state = 2'd2;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; state = 2'd0; Mode = 1'b0; value = 7'd0;
    char_valid = 1'b0; char_correct = 1'b0;
    step(2);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    chk("rst_correct", 32'(correct_cnt), 32'd0);
    chk("rst_error", 32'(error_cnt), 32'd0);
    chk("rst_elapsed", 32'(elapsed), 32'd0);
    chk("rst_disp", 32'(disp), 32'hCCCC);
    rst = 1'b0;

    // Time mode, 15 seconds: ticks on edges 10,20..150, finish on edge 151
    start_game(1'b0, 7'd15);
    chk("t_entry_rem", 32'(remaining), 32'd15);
    step(9);
    chk("t_pre_tick_rem", 32'(remaining), 32'd15);
    step(1);
    chk("t_tick1_rem", 32'(remaining), 32'd14);
    chk("t_tick1_elapsed", 32'(elapsed), 32'd1);
    chk("t_disp", 32'(disp), 32'h0014);
    step(139);
    chk("t_149_rem", 32'(remaining), 32'd1);
    step(1);
    chk("t_150_rem", 32'(remaining), 32'd0);
    chk("t_150_finish", 32'(finish), 32'd0);
    chk("t_150_elapsed", 32'(elapsed), 32'd15);
    step(1);
    chk("t_151_finish", 32'(finish), 32'd1);
    step(20);
    chk("t_frozen_elapsed", 32'(elapsed), 32'd15);
    chk("t_frozen_finish", 32'(finish), 32'd1);

    // Count mode, 25 chars, 4 wrong interleaved; 25th correct lands on edge 85
    start_game(1'b1, 7'd25);
    for (int i = 1; i <= 24; i++) begin
      pulse(1'b1);
      if (i % 5 == 0) pulse(1'b0);
    end
    chk("c_rem_before_last", 32'(remaining), 32'd1);
    char_valid = 1'b1; char_correct = 1'b1;
    step(1);
    char_valid = 1'b0;
    chk("c_rem_zero", 32'(remaining), 32'd0);
    chk("c_finish_not_yet", 32'(finish), 32'd0);
    step(1);
    chk("c_finish", 32'(finish), 32'd1);
    chk("c_correct", 32'(correct_cnt), 32'd25);
    chk("c_error", 32'(error_cnt), 32'd4);
    chk("c_elapsed", 32'(elapsed), 32'd8);
    pulse(1'b0);
    chk("c_after_finish_err", 32'(error_cnt), 32'd4);
    state = 2'd3;
    step(1);
    pulse(1'b1);
    pulse(1'b0);
    step(30);
    chk("f_disp", 32'(disp), 32'hD025);
    chk("f_correct", 32'(correct_cnt), 32'd25);
    chk("f_error", 32'(error_cnt), 32'd4);
    chk("f_elapsed", 32'(elapsed), 32'd8);
    chk("f_finish", 32'(finish), 32'd1);
    state = 2'd0;
    step(1);
    chk("s_finish_clr", 32'(finish), 32'd0);
    chk("s_reload", 32'(remaining), 32'd25);
    chk("s_correct_clr", 32'(correct_cnt), 32'd0);
    chk("s_disp", 32'(disp), 32'hCCCC);

    // Count mode: correct keystroke coincident with the first tick (edge 10)
    start_game(1'b1, 7'd50);
    step(9);
    char_valid = 1'b1; char_correct = 1'b1;
    step(1);
    char_valid = 1'b0;
    chk("co_rem", 32'(remaining), 32'd49);
    chk("co_elapsed", 32'(elapsed), 32'd1);
    chk("co_correct", 32'(correct_cnt), 32'd1);

    // value 0: finish one edge after entry
    start_game(1'b0, 7'd0);
    chk("z_finish_entry", 32'(finish), 32'd0);
    step(1);
    chk("z_finish", 32'(finish), 32'd1);
    chk("z_elapsed", 32'(elapsed), 32'd0);

    // Reset mid-game with remaining=7
    start_game(1'b0, 7'd10);
    step(30);
    chk("r_rem7", 32'(remaining), 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("r_async_rem", 32'(remaining), 32'd0);
    chk("r_async_elapsed", 32'(elapsed), 32'd0);
    chk("r_async_finish", 32'(finish), 32'd0);
    step(1);
    rst = 1'b0;

    // 300 consecutive wrong keystrokes in time mode
    start_game(1'b0, 7'd100);
    char_valid = 1'b1; char_correct = 1'b0;
    step(300);
    char_valid = 1'b0;
    chk("sat_error", 32'(error_cnt), 32'd255);
    chk("sat_rem", 32'(remaining), 32'd70);
    chk("sat_elapsed", 32'(elapsed), 32'd30);
    chk("sat_correct", 32'(correct_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_progress_tracker.md
Name: game_progress_tracker

Overview:
- Companion to the game control FSM; the opposite end of the control handshake.
- Consumes the controller's `state`, `Mode` and `value` outputs, plus per-keystroke results from the character matcher.
- Runs the in-game countdown (time mode) or the remaining-character count (count mode), and returns `finish` to the controller.
- Keeps correct/error/elapsed statistics and produces BCD digits for the 7-segment driver.

Parameters:
- TICKS_PER_SEC, 100000000: clk cycles per one-second game tick; benches override it small.
- ELAPSED_MAX, 999: saturation value of the elapsed-seconds counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- state  in  2  controller state: 0=SELECT, 1=COUNTDOWN, 2=INGAME, 3=FINISH
- Mode  in  1  0=time mode (value = seconds), 1=count mode (value = characters); stable outside SELECT
- value  in  7  game target, 0..100
- char_valid  in  1  one-cycle pulse, one keystroke evaluated
- char_correct  in  1  qualifies char_valid: 1=correct, 0=wrong
- finish  out  1  game-over indication to the controller
- remaining  out  7  seconds or characters left
- correct_cnt  out  8  correct keystrokes this game
- error_cnt  out  8  wrong keystrokes this game
- elapsed  out  10  whole seconds spent in INGAME
- disp  out  16  four BCD nibbles, nibble[3:0] = ones

Behaviour:
- Async reset clears every register: finish=0, remaining=0, all counters=0, prescaler=0.
- All outputs are registered except `disp`, which is combinational from the registers.

SELECT / COUNTDOWN (state 0 or 1), every cycle:
- remaining<=value; correct_cnt, error_cnt, elapsed, prescaler <= 0; finish<=0.
- char_valid is ignored.
- As a result, the INGAME entry values equal the `value` sampled on the last COUNTDOWN cycle.

INGAME (state 2), while finish==0:
- Prescaler counts 0..TICKS_PER_SEC-1 and wraps; tick = (prescaler==TICKS_PER_SEC-1).
- First tick occurs TICKS_PER_SEC cycles after INGAME entry.
- On tick: elapsed<=min(elapsed+1, ELAPSED_MAX).
- On tick in time mode: remaining<=remaining-1 if nonzero.
- char_valid & char_correct: correct_cnt+1, saturating at 255.
- Count mode additionally: remaining<=remaining-1 if nonzero.
- char_valid & !char_correct: error_cnt+1, saturating at 255; remaining unchanged.
- Tick and keystroke in the same cycle are both applied.
  - Time mode: decrement only once, from the tick.
  - Count mode: tick only updates elapsed.
- Terminal condition: remaining==0 as a register value.
  - finish<=1 on the next edge.
  - Latency: 1 cycle after remaining becomes 0.
  - value==0 gives finish 1 cycle after INGAME entry.
- remaining never underflows; it holds at 0.

INGAME with finish==1:
- All counters and the prescaler freeze; keystrokes are ignored.
- finish stays 1.

FINISH (state 3):
- Everything frozen; finish held at 1 until state returns to SELECT (cleared there on the next edge).

Reset mid-game:
- Immediate clear; the tracker then follows whatever `state` the controller presents.

Illegal sequencing:
- If state leaves INGAME for SELECT/COUNTDOWN, the block reverts to the reload behaviour above.

disp:
- state 2: {4'd0, hundreds, tens, ones of remaining}.
- state 3: {4'd13, hundreds, tens, ones of correct_cnt}; 13 = score glyph.
- States 0/1: 16'hCCCC (blank code 12).

Test Plan:
- Time mode, TICKS_PER_SEC=10, value=15, state 0→1→2 held -> remaining decrements every 10 cycles; remaining=0 at cycle 150 after entry; finish=1 at cycle 151; elapsed=15.
- Count mode, value=25: 25 correct pulses spaced 3 cycles, 4 wrong pulses interleaved -> remaining 0 after the 25th correct; finish next cycle; correct_cnt=25; error_cnt=4.
- Count mode, char_valid&char_correct coincident with tick -> remaining drops by 1 only; elapsed+1; correct_cnt+1.
- After finish, state=3: further pulses and ticks -> counters unchanged, disp=16'hD025 for correct_cnt=25; state→0 -> finish=0 next edge; remaining=value.
- value=0, INGAME entry -> finish=1 exactly one cycle later; elapsed=0.
- rst asserted mid-INGAME with remaining=7 -> all outputs 0 asynchronously; 300 wrong pulses in one game -> error_cnt saturates at 255.
